// File: rtl/phase_count_pkg.sv
// Shared types and per-layer parameter sets for the layer phase counters.
package phase_count_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_t;

   // Per-layer sets, all WIDTH=4 with three taps (slice 0 is the LSB slice).
   localparam int               L1_PERIOD  = 11;
   localparam int               L1_INIT    = 6;
   localparam logic [11:0]      L1_TAP_POS = {4'd6, 4'd10, 4'd5};
   localparam int               L2_PERIOD  = 9;
   localparam int               L2_INIT    = 0;
   localparam logic [11:0]      L2_TAP_POS = {4'd3, 4'd8, 4'd1};
   localparam int               L3_PERIOD  = 13;
   localparam int               L3_INIT    = 4;
   localparam logic [11:0]      L3_TAP_POS = {4'd4, 4'd12, 4'd7};
   localparam int               L4_PERIOD  = 7;
   localparam int               L4_INIT    = 0;
   localparam logic [11:0]      L4_TAP_POS = {4'd2, 4'd6, 4'd3};
   localparam int               L5_PERIOD  = 16;
   localparam int               L5_INIT    = 0;
   localparam logic [11:0]      L5_TAP_POS = {4'd0, 4'd15, 4'd8};
   localparam int               L6_PERIOD  = 12;
   localparam int               L6_INIT    = 2;
   localparam logic [11:0]      L6_TAP_POS = {4'd2, 4'd11, 4'd6};
   localparam int               L7_PERIOD  = 10;
   localparam int               L7_INIT    = 5;
   localparam logic [11:0]      L7_TAP_POS = {4'd5, 4'd9, 4'd4};
   localparam int               L8_PERIOD  = 14;
   localparam int               L8_INIT    = 0;
   localparam logic [11:0]      L8_TAP_POS = {4'd1, 4'd13, 4'd7};
   localparam int               L9_PERIOD  = 8;
   localparam int               L9_INIT    = 3;
   localparam logic [11:0]      L9_TAP_POS = {4'd3, 4'd7, 4'd0};

endpackage

// File: rtl/phase_count_gen_tap_decode.sv
// Bank of N_TAP equality comparators against constant tap positions.
module tap_decode #(
   parameter int                     WIDTH   = 4,
   parameter int                     N_TAP   = 3,
   parameter logic [N_TAP*WIDTH-1:0] TAP_POS = '0
) (
   input  logic [WIDTH-1:0] count,
   output logic [N_TAP-1:0] hit
);

   genvar gi;
   generate
      for (gi = 0; gi < N_TAP; gi++) begin : g_tap
         assign hit[gi] = (count == TAP_POS[gi*WIDTH +: WIDTH]);
      end
   endgenerate

endmodule

// File: rtl/phase_count_gen.sv
// Triggered modulo-PERIOD phase counter with tap decode, pass counting and a
// done state after NUM_PASS completed periods.
module phase_count_gen
   import phase_count_pkg::*;
#(
   parameter int                     WIDTH    = 4,
   parameter int                     PERIOD   = L1_PERIOD,
   parameter int                     INIT     = L1_INIT,
   parameter int                     N_TAP    = 3,
   parameter logic [N_TAP*WIDTH-1:0] TAP_POS  = L1_TAP_POS,
   parameter int                     NUM_PASS = 4,
   parameter int                     PW       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_zero,
   input  logic             stall,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic             count_active,
   output logic [N_TAP-1:0] tap_hit,
   output logic             wrap,
   output logic [PW-1:0]    pass_cnt,
   output logic             all_done
);

   localparam logic [WIDTH-1:0] LAST_V     = WIDTH'(PERIOD - 1);
   localparam logic [WIDTH-1:0] INIT_V     = WIDTH'(INIT);
   localparam logic [PW:0]      NUM_PASS_V = (PW+1)'(NUM_PASS);

   genvar gi;
   generate
      if (INIT >= PERIOD) begin : g_bad_init
         $error("phase_count_gen: INIT must be below PERIOD");
      end
      if (PERIOD > (1 << WIDTH)) begin : g_bad_period
         $error("phase_count_gen: PERIOD does not fit in WIDTH bits");
      end
      if (NUM_PASS >= (1 << PW)) begin : g_bad_pass
         $error("phase_count_gen: NUM_PASS does not fit in PW bits");
      end
      for (gi = 0; gi < N_TAP; gi++) begin : g_chk_tap
         if (int'(TAP_POS[gi*WIDTH +: WIDTH]) >= PERIOD) begin : g_bad_tap
            $error("phase_count_gen: TAP_POS slice must be below PERIOD");
         end
      end
   endgenerate

   logic [WIDTH-1:0] count_q, count_d;
   logic [PW-1:0]    pass_q, pass_d;
   state_t           state_q, state_d;
   logic             advance;
   logic             at_last;
   logic [PW:0]      pass_inc;

   assign at_last  = (count_q == LAST_V);
   assign advance  = (state_q == RUN) && !stall && (x_zero || (count_q != '0));
   assign pass_inc = {1'b0, pass_q} + (PW+1)'(1);

   always_comb begin
      count_d = count_q;
      pass_d  = pass_q;
      state_d = state_q;
      if (clr) begin
         count_d = INIT_V;
         pass_d  = '0;
         state_d = RUN;
      end else if (advance) begin
         if (at_last) begin
            count_d = '0;
            pass_d  = pass_inc[PW-1:0];
            // NUM_PASS of zero means free-running: the pass count just rolls over.
            if ((NUM_PASS != 0) && (pass_inc == NUM_PASS_V)) begin
               state_d = DONE;
            end
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= INIT_V;
         pass_q  <= '0;
         state_q <= RUN;
      end else begin
         count_q <= count_d;
         pass_q  <= pass_d;
         state_q <= state_d;
      end
   end

   tap_decode #(
      .WIDTH   (WIDTH),
      .N_TAP   (N_TAP),
      .TAP_POS (TAP_POS)
   ) u_tap_decode (
      .count (count_q),
      .hit   (tap_hit)
   );

   assign count        = count_q;
   assign pass_cnt     = pass_q;
   assign all_done     = (state_q == DONE);
   assign wrap         = at_last && advance;
   assign count_active = x_zero || (count_q != '0);

endmodule

// File: tb/tb_phase_count_gen.sv
// Randomised and directed checks of phase_count_gen against a cycle model.
module tb_phase_count_gen;

   localparam int PER = 11;
   localparam int INI = 6;
   localparam int NP  = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, x_zero, stall, clr;
   logic [3:0] count;
   logic       count_active, wrap, all_done;
   logic [2:0] tap_hit;
   logic [7:0] pass_cnt;

   logic x_zero1, stall1, clr1;
   logic [3:0] count1;
   logic       count_active1, wrap1, all_done1;
   logic [2:0] tap_hit1;
   logic [7:0] pass_cnt1;

   phase_count_gen dut (
      .clk(clk), .rst(rst), .x_zero(x_zero), .stall(stall), .clr(clr),
      .count(count), .count_active(count_active), .tap_hit(tap_hit),
      .wrap(wrap), .pass_cnt(pass_cnt), .all_done(all_done)
   );

   phase_count_gen #(
      .WIDTH(4), .PERIOD(16), .INIT(0), .N_TAP(3),
      .TAP_POS({4'd15, 4'd8, 4'd0}), .NUM_PASS(0), .PW(8)
   ) dut_wide (
      .clk(clk), .rst(rst), .x_zero(x_zero1), .stall(stall1), .clr(clr1),
      .count(count1), .count_active(count_active1), .tap_hit(tap_hit1),
      .wrap(wrap1), .pass_cnt(pass_cnt1), .all_done(all_done1)
   );

   wire [17:0] dut0 = {count, pass_cnt, all_done, tap_hit, wrap, count_active};
   wire [13:0] dut1 = {count1, pass_cnt1, all_done1, wrap1};

   int m_cnt, m_pass, n_cnt, n_pass;
   bit m_done;
   int tap_pos[3] = '{5, 10, 6};
   int checks = 0;
   int fails  = 0;

   function logic [17:0] exp0();
      logic [2:0] t;
      logic       adv;
      for (int i = 0; i < 3; i++) t[i] = (m_cnt == tap_pos[i]);
      adv = !m_done && !stall && (x_zero || m_cnt != 0);
      return {4'(m_cnt), 8'(m_pass), m_done, t, (m_cnt == PER - 1) && adv, x_zero || (m_cnt != 0)};
   endfunction

   function logic [13:0] exp1();
      return {4'(n_cnt), 8'(n_pass), 1'b0, (n_cnt == 15) && !stall1 && (x_zero1 || n_cnt != 0)};
   endfunction

   task automatic model_reset();
      m_cnt = INI; m_pass = 0; m_done = 0;
      n_cnt = 0;   n_pass = 0;
   endtask

   // Advance one clock and apply the behavioural rules to both models.
   task automatic tick();
      @(posedge clk);
      if (!rst) begin
         model_reset();
      end else begin
         if (clr) begin
            m_cnt = INI; m_pass = 0; m_done = 0;
         end else if (!m_done && !stall && (x_zero || m_cnt != 0)) begin
            m_cnt = (m_cnt + 1) % PER;
            if (m_cnt == 0) begin
               m_pass = (m_pass + 1) % 256;
               if (m_pass == NP) m_done = 1;
            end
         end
         if (clr1) begin
            n_cnt = 0; n_pass = 0;
         end else if (!stall1 && (x_zero1 || n_cnt != 0)) begin
            n_cnt = (n_cnt + 1) % 16;
            if (n_cnt == 0) n_pass = (n_pass + 1) % 256;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst = 0; x_zero = 0; stall = 0; clr = 0;
      x_zero1 = 0; stall1 = 0; clr1 = 0;
      model_reset();
      repeat (2) tick();
      @(negedge clk);
      checks++;
      if (dut0 !== exp0() || count !== 4'd6 || pass_cnt !== 8'd0 || all_done !== 1'b0) begin
         fails++;
         $display("FAIL reset_state got=%h exp=%h", dut0, exp0());
      end
      tick();
      rst = 1;
      $display("test_reset done");
   endtask

   task automatic test_init_run();
      int seq[8] = '{6, 7, 8, 9, 10, 0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checks++;
         if (dut0 !== exp0() || count !== 4'(seq[i]) || wrap !== (i == 4)) begin
            fails++;
            $display("FAIL init_run step=%0d got=%h exp=%h count=%0d req=%0d", i, dut0, exp0(), count, seq[i]);
         end
         tick();
      end
      checks++;
      if (pass_cnt !== 8'd1) begin
         fails++;
         $display("FAIL init_run_pass got=%0d exp=1", pass_cnt);
      end
      $display("test_init_run done");
   endtask

   task automatic test_pulse();
      x_zero = 1;
      @(negedge clk);
      checks++;
      if (dut0 !== exp0()) begin
         fails++;
         $display("FAIL pulse_start got=%h exp=%h", dut0, exp0());
      end
      tick();
      x_zero = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         checks++;
         if (dut0 !== exp0() || tap_hit[0] !== (count == 4'd5)) begin
            fails++;
            $display("FAIL pulse_run step=%0d got=%h exp=%h", i, dut0, exp0());
         end
         tick();
      end
      @(negedge clk);
      checks++;
      if (count_active !== 1'b0 || count !== 4'd0) begin
         fails++;
         $display("FAIL pulse_idle active=%0b count=%0d exp active=0 count=0", count_active, count);
      end
      $display("test_pulse done");
   endtask

   task automatic test_full_passes();
      int budget = 80;
      clr = 1; tick(); clr = 0;
      x_zero = 1;
      while (all_done !== 1'b1 && budget > 0) begin
         @(negedge clk);
         checks++;
         if (dut0 !== exp0()) begin
            fails++;
            $display("FAIL full_passes got=%h exp=%h", dut0, exp0());
         end
         tick();
         budget--;
      end
      checks++;
      if (all_done !== 1'b1 || pass_cnt !== 8'd4) begin
         fails++;
         $display("FAIL full_passes_done all_done=%0b pass=%0d exp 1/4", all_done, pass_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (dut0 !== exp0() || count !== 4'd0 || count_active !== 1'b1) begin
            fails++;
            $display("FAIL done_hold got=%h exp=%h", dut0, exp0());
         end
         tick();
      end
      x_zero = 0;
      $display("test_full_passes done");
   endtask

   task automatic test_stall();
      clr = 1; tick(); clr = 0;
      for (int i = 0; i < 4; i++) tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (dut0 !== exp0() || count !== 4'd10 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL stall_hold step=%0d count=%0d wrap=%0b exp 10/0", i, count, wrap);
         end
         tick();
      end
      stall = 0;
      @(negedge clk);
      checks++;
      if (wrap !== 1'b1 || pass_cnt !== 8'd0) begin
         fails++;
         $display("FAIL stall_release wrap=%0b pass=%0d exp 1/0", wrap, pass_cnt);
      end
      tick();
      @(negedge clk);
      checks++;
      if (dut0 !== exp0() || count !== 4'd0 || pass_cnt !== 8'd1) begin
         fails++;
         $display("FAIL stall_after got=%h exp=%h", dut0, exp0());
      end
      $display("test_stall done");
   endtask

   task automatic test_clr_priority();
      int budget = 60;
      clr = 1; tick(); clr = 0;
      x_zero = 1;
      while (!(pass_cnt == 8'd2 && count == 4'd7) && budget > 0) begin
         tick();
         budget--;
      end
      checks++;
      if (pass_cnt !== 8'd2 || count !== 4'd7) begin
         fails++;
         $display("FAIL clr_setup timeout pass=%0d count=%0d exp 2/7", pass_cnt, count);
      end
      clr = 1; stall = 1;
      tick();
      clr = 0; stall = 0; x_zero = 0;
      @(negedge clk);
      checks++;
      if (dut0 !== exp0() || count !== 4'd6 || pass_cnt !== 8'd0 || all_done !== 1'b0) begin
         fails++;
         $display("FAIL clr_stall got=%h exp=%h", dut0, exp0());
      end
      x_zero = 1;
      budget = 80;
      while (all_done !== 1'b1 && budget > 0) begin
         tick();
         budget--;
      end
      clr = 1; x_zero = 0;
      tick();
      clr = 0;
      @(negedge clk);
      checks++;
      if (dut0 !== exp0() || all_done !== 1'b0 || count !== 4'd6) begin
         fails++;
         $display("FAIL clr_from_done all_done=%0b count=%0d exp 0/6", all_done, count);
      end
      $display("test_clr_priority done");
   endtask

   task automatic test_async_reset();
      int budget = 40;
      x_zero = 1;
      while (!(pass_cnt >= 8'd1 && count == 4'd8) && budget > 0) begin
         tick();
         budget--;
      end
      x_zero = 0;
      #2;
      rst = 0;
      model_reset();
      #1;
      checks++;
      if (count !== 4'd6 || pass_cnt !== 8'd0 || all_done !== 1'b0) begin
         fails++;
         $display("FAIL async_reset count=%0d pass=%0d exp 6/0", count, pass_cnt);
      end
      tick();
      rst = 1;
      $display("test_async_reset done");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         x_zero = ($urandom_range(0, 3) == 0);
         stall  = ($urandom_range(0, 3) == 0);
         clr    = ($urandom_range(0, 49) == 0);
         @(negedge clk);
         checks++;
         if (dut0 !== exp0()) begin
            fails++;
            $display("FAIL random cyc=%0d got=%h exp=%h", i, dut0, exp0());
         end
         tick();
      end
      x_zero = 0; stall = 0; clr = 0;
      $display("test_random done");
   endtask

   task automatic test_wide();
      bit rolled = 0;
      logic [7:0] prev = pass_cnt1;
      x_zero1 = 1;
      for (int i = 0; i < 16 * 256 + 20; i++) begin
         @(negedge clk);
         checks++;
         if (dut1 !== exp1()) begin
            fails++;
            $display("FAIL wide cyc=%0d got=%h exp=%h", i, dut1, exp1());
         end
         if (prev == 8'd255 && pass_cnt1 == 8'd0) rolled = 1;
         prev = pass_cnt1;
         tick();
      end
      checks++;
      if (!rolled) begin
         fails++;
         $display("FAIL wide_rollover pass_cnt never rolled 255->0, now=%0d", pass_cnt1);
      end
      x_zero1 = 0;
      $display("test_wide done");
   endtask

   initial begin
      test_reset();
      test_init_run();
      test_pulse();
      test_full_passes();
      test_stall();
      test_clr_priority();
      test_async_reset();
      test_random();
      test_wide();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
